bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised N-digit BCD up/down counter: the next-generation successor to the fixed 8-digit chain. It adds a generic digit count, a wrap or saturate mode, synchronous clear, and both single-digit and whole-word parallel load. It adds a registered carry/borrow pulse and rejects invalid (non-BCD) load values. It feeds the display/readout path and serves as a programmable event or cycle counter.

## Interface
Parameters:
- DIGITS, 8, number of BCD digits (1..16)
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value
- SEL_W, derived localparam = max(1, $clog2(DIGITS)), digit-select width (not overridable)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable (one step per enabled cycle)
- up  in  1  direction: 1 = increment, 0 = decrement
- clr  in  1  synchronous clear of all digits to 0
- load_dig  in  1  load dig_val into digit dig_sel
- dig_sel  in  SEL_W  target digit index, 0 = least significant
- dig_val  in  4  value for single-digit load
- load_all  in  1  load all_val into the whole counter
- all_val  in  4*DIGITS  parallel load word, digit i at [4i+3:4i]
- count  out  4*DIGITS  current value, digit i at [4i+3:4i]
- carry_out  out  1  one-cycle pulse on wrap (up: 9..9→0..0, down: 0..0→9..9)
- at_limit  out  1  combinational: count is all 9s when up=1, or all 0s when up=0
- invalid  out  1  one-cycle pulse: the previous cycle's load was rejected

## Operation
- Priority per cycle: rst > clr > load_all > load_dig > count (en). Exactly one action takes effect.
- rst: count=0, carry_out=0, invalid=0.
- clr: count=0, carry_out=0. Accepted load requests and en are ignored in that cycle.
- load_all: if every nibble of all_val is ≤9, count=all_val. Otherwise count holds and invalid pulses.
- load_dig: if dig_val≤9 and dig_sel<DIGITS, only digit dig_sel is replaced and the others hold. Otherwise count holds and invalid pulses.
- Count up: digit i increments when all digits below it are 9. A digit at 9 rolls to 0. The whole counter moves one step per cycle; there is no multi-cycle ripple.
- Count down: digit i decrements when all digits below it are 0. A digit at 0 rolls to 9.
- Terminal with SATURATE=0: wraps and carry_out pulses.
- Terminal with SATURATE=1: count holds at the terminal value, carry_out stays 0, and at_limit stays high.
- en=0 with no clear or load: count holds and carry_out=0.
- A direction change takes effect on the next enabled step; there is no pipeline to flush.
- Digits never hold values >9 under any input sequence.

## Timing
- All outputs except at_limit are registered. Results appear one cycle after the request edge.
- carry_out is asserted in the same cycle that count first shows the wrapped value. It lasts exactly one cycle, even when en stays high.
- invalid is asserted one cycle after the rejected request, for one cycle. Consecutive rejected requests give consecutive pulses.
- at_limit follows count and up combinationally, with zero latency.
- rst mid-count: count=0 on the next edge, and any pending carry_out or invalid pulse is cancelled.
- Loads and en in the same cycle: the load wins and no count step occurs that cycle.

## Structure
- Shared package bcd_pkg:
  - bcd_t (4-bit digit type)
  - BCD_MAX=4'd9, BCD_MIN=4'd0
  - function is_bcd(bcd_t)
- Sub-module bcd_digit_cell: one digit register with load, clear, and step-up/step-down inputs, generated DIGITS times.
- Enable lookahead (all-lower-digits-at-9 or all-lower-digits-at-0) is computed in the parent as prefix-AND chains.
- bcd_digit_cell outputs is_max and is_min to feed those chains.

## Test plan
- DIGITS=4, SATURATE=0: load_all 16'h9998, up, en for 3 cycles → count 9999, 0000 (carry_out=1 that cycle only), 0001.
- DIGITS=4: from reset, up=0, en=1 → count 9999 next cycle with carry_out=1. Then 9998, with carry_out=0.
- DIGITS=4, SATURATE=1: load_all 16'h9999, en with up=1 for 5 cycles → count stays 9999, at_limit=1, carry_out never asserted.
- load_dig dig_sel=2, dig_val=4'hA on count 1234 → count stays 1234, invalid=1 next cycle. Repeat with dig_val=7 → 1734, invalid=0.
- DIGITS=6: dig_sel=6 with load_dig → ignored, invalid pulses. load_all with nibble 4'hF in digit 5 → count unchanged, invalid pulses.
- Same-cycle conflicts: clr+load_all+en → 0. load_all 0042 + en → 0042 (no step). rst asserted mid-count at 0999 → 0000, no carry_out.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit bounds and a validity check.
package bcd_pkg;
   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   function automatic logic is_bcd(input bcd_t d);
      return (d <= BCD_MAX);
   endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register.
// Ports: clk/rst (sync, active-high), clr_i (force 0), ld_i/ld_val_i (load),
//        inc_i/dec_i (single step with 9<->0 roll), q_o (digit),
//        is_max_o/is_min_o (digit at 9 / at 0, feed the parent's lookahead).
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic ld_i,
   input  bcd_t ld_val_i,
   input  logic inc_i,
   input  logic dec_i,
   output bcd_t q_o,
   output logic is_max_o,
   output logic is_min_o
);
   bcd_t q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr_i)                           q_d = BCD_MIN;
      // The parent only loads validated values; the local guard keeps the
      // digit in range even if that ever changes.
      else if (ld_i && is_bcd(ld_val_i))   q_d = ld_val_i;
      else if (inc_i)                      q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else if (dec_i)                      q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= BCD_MIN;
      else     q_q <= q_d;
   end

   assign q_o      = q_q;
   assign is_max_o = (q_q == BCD_MAX);
   assign is_min_o = (q_q == BCD_MIN);
endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with wrap/saturate, clear, whole-word and
// single-digit load, registered carry pulse and invalid-load pulse.
// Ports: clk, rst (sync, active-high), en, up, clr, load_dig/dig_sel/dig_val,
//        load_all/all_val, count (digit i at [4i+3:4i]), carry_out (wrap
//        pulse), at_limit (combinational terminal flag), invalid (reject pulse).
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int  DIGITS   = 8,
   parameter bit  SATURATE = 1'b0,
   localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   input  logic                  load_dig,
   input  logic [SEL_W-1:0]      dig_sel,
   input  logic [3:0]            dig_val,
   input  logic                  load_all,
   input  logic [4*DIGITS-1:0]   all_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry_out,
   output logic                  at_limit,
   output logic                  invalid
);
   logic [DIGITS-1:0] is_max, is_min;
   // lo9[i]/lo0[i]: every digit below i is 9 / 0. Index DIGITS covers the word.
   logic [DIGITS:0]   lo9, lo0;
   logic              all_ok, dig_ok, term, do_all, do_dig, step;
   logic              carry_q, carry_d, inv_q, inv_d;

   assign lo9[0] = 1'b1;
   assign lo0[0] = 1'b1;

   always_comb begin
      all_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (!is_bcd(all_val[4*i +: 4])) all_ok = 1'b0;
   end

   assign dig_ok = is_bcd(dig_val) && (32'(dig_sel) < DIGITS);
   assign term   = up ? lo9[DIGITS] : lo0[DIGITS];

   // Priority clr > load_all > load_dig > step. A rejected load still
   // occupies the cycle, so it blocks the count step.
   assign do_all = !clr && load_all && all_ok;
   assign do_dig = !clr && !load_all && load_dig && dig_ok;
   assign step   = en && !clr && !load_all && !load_dig && !(SATURATE && term);

   assign carry_d = step && term;
   assign inv_d   = !clr && (load_all ? !all_ok : (load_dig && !dig_ok));

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic ld;
      bcd_t ld_val;

      assign ld     = do_all || (do_dig && (32'(dig_sel) == i));
      assign ld_val = do_all ? all_val[4*i +: 4] : dig_val;
      assign lo9[i+1] = lo9[i] && is_max[i];
      assign lo0[i+1] = lo0[i] && is_min[i];

      bcd_digit_cell u_cell (
         .clk      (clk),
         .rst      (rst),
         .clr_i    (clr),
         .ld_i     (ld),
         .ld_val_i (ld_val),
         .inc_i    (step && up && lo9[i]),
         .dec_i    (step && !up && lo0[i]),
         .q_o      (count[4*i +: 4]),
         .is_max_o (is_max[i]),
         .is_min_o (is_min[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         carry_q <= carry_d;
         inv_q   <= inv_d;
      end
   end

   assign carry_out = carry_q;
   assign invalid   = inv_q;
   assign at_limit  = term;
endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;
   logic        clk = 1'b0;
   logic        rst, en, up, clr, load_dig, load_all;
   logic [2:0]  dig_sel;
   logic [3:0]  dig_val;
   logic [23:0] all_val;

   logic [15:0] c4, c4s;
   logic [23:0] c6;
   logic        cy4, lim4, inv4, cy4s, lim4s, inv4s, cy6, lim6, inv6;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u4 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
      .load_dig(load_dig), .dig_sel(dig_sel[1:0]), .dig_val(dig_val),
      .load_all(load_all), .all_val(all_val[15:0]),
      .count(c4), .carry_out(cy4), .at_limit(lim4), .invalid(inv4));

   bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1)) u4s (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
      .load_dig(load_dig), .dig_sel(dig_sel[1:0]), .dig_val(dig_val),
      .load_all(load_all), .all_val(all_val[15:0]),
      .count(c4s), .carry_out(cy4s), .at_limit(lim4s), .invalid(inv4s));

   bcd_counter_n #(.DIGITS(6), .SATURATE(1'b0)) u6 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
      .load_dig(load_dig), .dig_sel(dig_sel), .dig_val(dig_val),
      .load_all(load_all), .all_val(all_val),
      .count(c6), .carry_out(cy6), .at_limit(lim6), .invalid(inv6));

   typedef struct {
      logic        rst, clr, en, up, ld_all, ld_dig;
      logic [2:0]  sel;
      logic [3:0]  dval;
      logic [15:0] aval;
      logic [15:0] e_cnt;
      logic        e_cy, e_inv, e_lim;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, c, e, u, la, ld, input logic [2:0] s,
                      input logic [3:0] dv, input logic [15:0] av,
                      input logic [15:0] ec, input logic ecy, einv, elim);
      vec_t v;
      v.rst = r; v.clr = c; v.en = e; v.up = u; v.ld_all = la; v.ld_dig = ld;
      v.sel = s; v.dval = dv; v.aval = av;
      v.e_cnt = ec; v.e_cy = ecy; v.e_inv = einv; v.e_lim = elim;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      rst = 0; en = 0; up = 1; clr = 0; load_dig = 0; load_all = 0;
      dig_sel = 0; dig_val = 0; all_val = 0;
   endtask

   // Drive inputs, then sample 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      //   rst clr en up la ld sel dval aval      cnt      cy inv lim
      add(1, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0); // reset
      add(0, 0, 0, 1, 1, 0, 0, 0, 16'h9998, 16'h9998, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 1);
      add(0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0); // wrap up
      add(0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0); // pulse ends
      add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h9999, 1, 0, 0); // wrap down
      add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h9998, 0, 0, 0);
      add(0, 0, 0, 1, 1, 0, 0, 0, 16'h1234, 16'h1234, 0, 0, 0);
      add(0, 0, 0, 1, 0, 1, 2, 4'hA, 16'h0000, 16'h1234, 0, 1, 0); // bad digit
      add(0, 0, 0, 1, 0, 1, 2, 4'h7, 16'h0000, 16'h1734, 0, 0, 0);
      add(0, 0, 0, 1, 0, 1, 1, 4'hF, 16'h0000, 16'h1734, 0, 1, 0); // back-to-back
      add(0, 0, 0, 1, 0, 1, 0, 4'hC, 16'h0000, 16'h1734, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h1734, 0, 0, 0);
      add(0, 1, 1, 1, 1, 0, 0, 0, 16'h5555, 16'h0000, 0, 0, 0); // clr wins
      add(0, 0, 1, 1, 1, 0, 0, 0, 16'h0042, 16'h0042, 0, 0, 0); // load beats en
      add(0, 0, 0, 1, 1, 0, 0, 0, 16'h0999, 16'h0999, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h1000, 0, 0, 0); // 3-digit ripple
      add(0, 0, 0, 1, 1, 0, 0, 0, 16'h0999, 16'h0999, 0, 0, 0);
      add(1, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0); // rst mid-count
      add(0, 0, 1, 1, 1, 0, 0, 0, 16'h12F4, 16'h0000, 0, 1, 0); // bad word, no step
      add(0, 0, 0, 1, 1, 1, 0, 4'h5, 16'h0019, 16'h0019, 0, 0, 0); // load_all > load_dig
      add(0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0020, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0020, 0, 0, 0);
      add(0, 0, 0, 1, 1, 0, 0, 0, 16'hFFFF, 16'h0020, 0, 1, 0);
      add(1, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; clr = vecs[i].clr; en = vecs[i].en; up = vecs[i].up;
         load_all = vecs[i].ld_all; load_dig = vecs[i].ld_dig;
         dig_sel = vecs[i].sel; dig_val = vecs[i].dval; all_val = {8'h00, vecs[i].aval};
         tick();
         chk($sformatf("v%0d count", i), 32'(c4), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d carry", i), 32'(cy4), 32'(vecs[i].e_cy));
         chk($sformatf("v%0d invalid", i), 32'(inv4), 32'(vecs[i].e_inv));
         chk($sformatf("v%0d at_limit", i), 32'(lim4), 32'(vecs[i].e_lim));
      end

      // Saturate, up: hold at 9999, never carry.
      idle(); rst = 1; tick();
      idle(); load_all = 1; all_val = 24'h009999; tick();
      idle(); en = 1; up = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("sat_up%0d count", k), 32'(c4s), 32'h9999);
         chk($sformatf("sat_up%0d at_limit", k), 32'(lim4s), 32'd1);
         chk($sformatf("sat_up%0d carry", k), 32'(cy4s), 32'd0);
      end

      // Saturate, down from reset: hold at 0000.
      idle(); rst = 1; tick();
      idle(); en = 1; up = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("sat_dn%0d count", k), 32'(c4s), 32'h0000);
         chk($sformatf("sat_dn%0d at_limit", k), 32'(lim4s), 32'd1);
         chk($sformatf("sat_dn%0d carry", k), 32'(cy4s), 32'd0);
      end
      // Saturated counter leaves the limit once direction flips.
      up = 1; tick();
      chk("sat_flip count", 32'(c4s), 32'h0001);

      // Six digits: out-of-range select and bad top nibble are rejected.
      idle(); rst = 1; tick();
      idle(); load_all = 1; all_val = 24'h123456; tick();
      chk("d6 load", 32'(c6), 32'h123456);
      idle(); load_dig = 1; dig_sel = 3'd6; dig_val = 4'd3; tick();
      chk("d6 sel6 count", 32'(c6), 32'h123456);
      chk("d6 sel6 invalid", 32'(inv6), 32'd1);
      idle(); load_all = 1; all_val = 24'hF23456; tick();
      chk("d6 badnib count", 32'(c6), 32'h123456);
      chk("d6 badnib invalid", 32'(inv6), 32'd1);
      idle(); load_dig = 1; dig_sel = 3'd5; dig_val = 4'd9; tick();
      chk("d6 sel5 count", 32'(c6), 32'h923456);
      chk("d6 sel5 invalid", 32'(inv6), 32'd0);
      idle(); load_all = 1; all_val = 24'h999999; tick();
      idle(); en = 1; up = 1; tick();
      chk("d6 wrap count", 32'(c6), 32'h000000);
      chk("d6 wrap carry", 32'(cy6), 32'd1);
      idle(); tick();
      chk("d6 idle carry", 32'(cy6), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got hang expected finish");
      $fatal(1);
   end
endmodule
